// File: rtl/fc_layer_scheduler.sv
// In-order launcher for the fully-connected layer engines: steps through the layers,
// steers the ping-pong activation banks, guards each layer with a watchdog and counts cycles.
module fc_layer_scheduler #(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 65536,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_ready,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [2:0]            layer_idx,
    output logic                  src_sel,
    output logic                  dst_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            err_layer,
    output logic [CNT_W-1:0]      total_cycles
);

    localparam int              WD_W   = $clog2(TIMEOUT);
    localparam logic [2:0]      LAST   = 3'(NUM_LAYERS - 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_NEXT, S_DONE, S_ERROR
    } state_t;

    state_t                state;
    logic [WD_W-1:0]       watchdog;
    logic [NUM_LAYERS-1:0] sel;
    logic                  ready_act;

    // One-hot select of the active layer; only its ready bit is ever looked at.
    generate
        for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_sel
            assign sel[i] = (layer_idx == 3'(i));
        end
    endgenerate

    assign ready_act   = |(layer_ready & sel);
    assign layer_start = (state == S_LAUNCH) ? sel : '0;
    assign busy        = (state == S_LAUNCH) || (state == S_WAIT) || (state == S_NEXT);
    assign done        = (state == S_DONE);
    assign src_sel     = layer_idx[0];
    assign dst_sel     = ~layer_idx[0];

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state        <= S_IDLE;
            layer_idx    <= '0;
            watchdog     <= '0;
            total_cycles <= '0;
            error        <= 1'b0;
            err_layer    <= '0;
        end else begin
            if (busy && (total_cycles != '1))
                total_cycles <= total_cycles + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state        <= S_LAUNCH;
                        layer_idx    <= '0;
                        total_cycles <= '0;
                    end
                end
                S_LAUNCH: begin
                    watchdog <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    // Completion beats abort, abort beats the watchdog.
                    if (ready_act) begin
                        state <= S_NEXT;
                    end else if (abort) begin
                        state <= S_IDLE;
                    end else if (watchdog == WD_MAX) begin
                        state     <= S_ERROR;
                        error     <= 1'b1;
                        err_layer <= layer_idx;
                    end
                end
                S_NEXT: begin
                    if (layer_idx == LAST) begin
                        state <= S_DONE;
                    end else begin
                        layer_idx <= layer_idx + 3'd1;
                        state     <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    if (start) begin
                        error        <= 1'b0;
                        err_layer    <= '0;
                        state        <= S_LAUNCH;
                        layer_idx    <= '0;
                        total_cycles <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Bench for fc_layer_scheduler: engine model plus a scoreboard of expected launch/done events,
// driven from a table of run profiles and a few hand sequences (timeout, abort, reset mid-run).
module tb_fc_layer_scheduler;

    localparam int NL    = 4;
    localparam int TO    = 16;
    localparam int CW    = 6;
    localparam int SAT   = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic          abort;
    logic [NL-1:0] layer_ready;
    logic [NL-1:0] layer_start;
    logic [2:0]    layer_idx;
    logic          src_sel;
    logic          dst_sel;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    err_layer;
    logic [CW-1:0] total_cycles;

    fc_layer_scheduler #(.NUM_LAYERS(NL), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
        .layer_ready(layer_ready), .layer_start(layer_start), .layer_idx(layer_idx),
        .src_sel(src_sel), .dst_sel(dst_sel), .busy(busy), .done(done),
        .error(error), .err_layer(err_layer), .total_cycles(total_cycles)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        logic [3:0] ls;
        logic       dn;
        logic       src;
    } ev_t;

    typedef struct {
        int d;
        int exp_total;
        bit noise;
        int abort_off;
    } vec_t;

    ev_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  t0    = 0;
    int  eng_delay = 10;
    int  silent    = -1;
    int  due[NL];
    bit  done_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, sample outputs, then run the engine model for the new cycle.
    task automatic step();
        ev_t e;
        @(posedge Clk);
        cyc++;
        #1;
        start = 1'b0;
        abort = 1'b0;
        if (layer_start != '0 || done) begin
            if (done) done_seen = 1;
            if (sb.size() == 0) begin
                chk("unexpected_start_or_done", {layer_start, done}, 0);
            end else begin
                e = sb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("event_layer_start", layer_start, e.ls);
                chk("event_done", done, e.dn);
                if (e.ls != 0) begin
                    chk("src_sel", src_sel, e.src);
                    chk("dst_sel", dst_sel, !e.src);
                end
            end
        end
        layer_ready = '0;
        for (int i = 0; i < NL; i++) begin
            if (due[i] == cyc) begin
                layer_ready[i] = 1'b1;
                due[i] = -1;
            end
            if (layer_start[i] && i != silent) due[i] = cyc + eng_delay;
        end
    endtask

    // Pulse start and queue the expected launches up to layer 'last' (-1: full run with done).
    task automatic launch_run(input int d, input int last, input int sil);
        ev_t e;
        eng_delay = d;
        silent    = sil;
        done_seen = 0;
        for (int i = 0; i < NL; i++) due[i] = -1;
        t0 = cyc;
        for (int k = 0; k < NL; k++) begin
            e.cyc = t0 + 1 + k * (d + 2);
            e.ls  = 4'(1 << k);
            e.dn  = 1'b0;
            e.src = k[0];
            sb.push_back(e);
            if (k == last) break;
        end
        if (last < 0) begin
            e.cyc = t0 + 1 + NL * (d + 2);
            e.ls  = '0;
            e.dn  = 1'b1;
            e.src = 1'b0;
            sb.push_back(e);
        end
        start = 1'b1;
        step();
        chk("error_clear_on_start", error, 0);
        chk("busy_in_launch", busy, 1);
    endtask

    task automatic step_to(input int c);
        for (int n = 0; n < 1000 && cyc < c; n++) step();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{d: 10, exp_total: 48,  noise: 0, abort_off: -1};
        vecs[1] = '{d: 10, exp_total: 48,  noise: 1, abort_off: -1};
        vecs[2] = '{d: 3,  exp_total: 20,  noise: 0, abort_off: -1};
        vecs[3] = '{d: 1,  exp_total: 12,  noise: 0, abort_off: -1};
        vecs[4] = '{d: 16, exp_total: SAT, noise: 0, abort_off: -1};
        vecs[5] = '{d: 10, exp_total: 48,  noise: 0, abort_off: 23};
        for (int i = 0; i < NL; i++) due[i] = -1;

        Reset = 1'b0; start = 1'b0; abort = 1'b0; layer_ready = '0;
        step(); step();
        chk("rst_layer_start", layer_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_layer", err_layer, 0);
        chk("rst_total", total_cycles, 0);
        chk("rst_layer_idx", layer_idx, 0);
        Reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        // Full runs: expected total = NL*(d+2), saturating at all-ones.
        foreach (vecs[r]) begin
            launch_run(vecs[r].d, -1, -1);
            for (int n = 0; n < 300 && !done_seen; n++) begin
                if (vecs[r].noise && cyc == t0 + 13) layer_ready |= 4'b0010;
                if (vecs[r].noise && cyc == t0 + 15) begin
                    layer_ready |= 4'b0101;
                    start = 1'b1;
                end
                if (cyc == t0 + vecs[r].abort_off) abort = 1'b1;
                step();
            end
            chk($sformatf("row%0d_done_seen", r), done_seen, 1);
            chk($sformatf("row%0d_total", r), total_cycles, vecs[r].exp_total);
            chk($sformatf("row%0d_layer_idx", r), layer_idx, NL - 1);
            chk($sformatf("row%0d_sb_empty", r), sb.size(), 0);
            step();
            chk($sformatf("row%0d_idle_busy", r), busy, 0);
        end

        // Watchdog: layer 2 (launched at t0+25) never readies; WAIT counts 0..TO-1, then ERROR.
        launch_run(10, 2, 2);
        step_to(t0 + 25 + TO);
        chk("to_error_not_yet", error, 0);
        chk("to_busy_before", busy, 1);
        step();
        chk("to_error", error, 1);
        chk("to_err_layer", err_layer, 2);
        chk("to_busy", busy, 0);
        chk("to_total", total_cycles, 25 + TO);
        for (int n = 0; n < 5; n++) step();
        chk("to_error_sticky", error, 1);
        chk("to_total_frozen", total_cycles, 25 + TO);
        chk("to_sb_empty", sb.size(), 0);
        launch_run(10, -1, -1);
        chk("to_err_layer_clear", err_layer, 0);
        for (int n = 0; n < 300 && !done_seen; n++) step();
        chk("to_rerun_done", done_seen, 1);
        chk("to_rerun_total", total_cycles, 48);

        // Abort during layer 1 WAIT: back to IDLE, idx kept, later ready ignored.
        step();
        launch_run(10, 1, -1);
        step_to(t0 + 15);
        abort = 1'b1;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_idx", layer_idx, 1);
        chk("abort_done", done, 0);
        for (int n = 0; n < 12; n++) step();
        chk("abort_idle_busy", busy, 0);
        chk("abort_sb_empty", sb.size(), 0);

        // Reset while layer 3 waits.
        launch_run(10, 3, -1);
        step_to(t0 + 40);
        chk("midrst_busy_before", busy, 1);
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        chk("midrst_idx", layer_idx, 0);
        chk("midrst_total", total_cycles, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_start", layer_start, 0);
        for (int n = 0; n < 10; n++) step();
        chk("midrst_idle_busy", busy, 0);
        chk("midrst_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
